// File: rtl/multi_fetch_unit.sv
// multi_fetch_unit: N independent instruction fetch channels, each with a PC, a fixed-latency ROM pipeline and an instruction FIFO.
// Define FETCH_PERF_EN to add per-channel saturating fetch/flush counters (perf_fetch_flat, perf_flush_flat).
module multi_fetch_unit #(
    parameter int                NUM_CH   = 5,
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 32,
    parameter int                ROM_LAT  = 2,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic [NUM_CH-1:0]        mem_en_flat,
    output logic [NUM_CH*ADDR_W-1:0] mem_addr_flat,
    input  logic [NUM_CH*DATA_W-1:0] mem_rdata_flat,
    output logic [NUM_CH-1:0]        inst_valid,
    input  logic [NUM_CH-1:0]        inst_ready,
    output logic [NUM_CH*DATA_W-1:0] inst_flat,
    output logic [NUM_CH*ADDR_W-1:0] inst_pc_flat,
    input  logic [NUM_CH-1:0]        jump_detected,
    input  logic [NUM_CH*ADDR_W-1:0] jump_addr_flat
`ifdef FETCH_PERF_EN
    ,
    output logic [NUM_CH*32-1:0]     perf_fetch_flat,
    output logic [NUM_CH*32-1:0]     perf_flush_flat
`endif
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int OCC_W   = $clog2(DEPTH + ROM_LAT + 1);
    localparam int ENTRY_W = DATA_W + ADDR_W;

    for (genvar k = 0; k < NUM_CH; k++) begin : gCh
        logic [ADDR_W-1:0]  pc_q, pc_d;
        logic [ROM_LAT-1:0] tagValid_q, tagValid_d;
        logic [ADDR_W-1:0]  tagPc_q [ROM_LAT];
        logic [ENTRY_W-1:0] fifoMem_q [DEPTH];
        logic [PTR_W-1:0]   wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
        logic [CNT_W-1:0]   count_q, count_d;
        logic [OCC_W-1:0]   occupancy;
        logic [ENTRY_W-1:0] head;
        logic [ADDR_W-1:0]  jumpAddr;
        logic [DATA_W-1:0]  rdata;
        logic               jump, issue, fifoWr, fifoPop, empty;

        assign jump     = jump_detected[k];
        assign jumpAddr = jump_addr_flat[k*ADDR_W +: ADDR_W];
        assign rdata    = mem_rdata_flat[k*DATA_W +: DATA_W];
        assign empty    = (count_q == '0);
        assign fifoPop  = !empty && inst_ready[k];
        assign fifoWr   = tagValid_q[ROM_LAT-1] && !jump;

        always_comb begin
            occupancy = OCC_W'(count_q);
            for (int i = 0; i < ROM_LAT; i++) begin
                occupancy = occupancy + OCC_W'(tagValid_q[i]);
            end
        end

        // Gating with rst keeps the ROM idle while reset is held low.
        assign issue = rst && !jump && (occupancy < OCC_W'(DEPTH));

        always_comb begin
            pc_d = pc_q;
            if (jump) begin
                pc_d = jumpAddr;
            end else if (issue) begin
                pc_d = pc_q + ADDR_W'(1);
            end
        end

        always_comb begin
            tagValid_d = '0;
            if (!jump) begin
                tagValid_d[0] = issue;
                for (int i = 1; i < ROM_LAT; i++) begin
                    tagValid_d[i] = tagValid_q[i-1];
                end
            end
        end

        always_comb begin
            wrPtr_d = wrPtr_q;
            rdPtr_d = rdPtr_q;
            count_d = count_q;
            if (jump) begin
                wrPtr_d = '0;
                rdPtr_d = '0;
                count_d = '0;
            end else begin
                if (fifoWr) begin
                    wrPtr_d = wrPtr_q + PTR_W'(1);
                end
                if (fifoPop) begin
                    rdPtr_d = rdPtr_q + PTR_W'(1);
                end
                case ({fifoWr, fifoPop})
                    2'b10:   count_d = count_q + CNT_W'(1);
                    2'b01:   count_d = count_q - CNT_W'(1);
                    default: count_d = count_q;
                endcase
            end
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                pc_q       <= RESET_PC;
                tagValid_q <= '0;
                wrPtr_q    <= '0;
                rdPtr_q    <= '0;
                count_q    <= '0;
                for (int i = 0; i < ROM_LAT; i++) begin
                    tagPc_q[i] <= '0;
                end
            end else begin
                pc_q       <= pc_d;
                tagValid_q <= tagValid_d;
                wrPtr_q    <= wrPtr_d;
                rdPtr_q    <= rdPtr_d;
                count_q    <= count_d;
                tagPc_q[0] <= pc_q;
                for (int i = 1; i < ROM_LAT; i++) begin
                    tagPc_q[i] <= tagPc_q[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (fifoWr) begin
                fifoMem_q[wrPtr_q] <= {rdata, tagPc_q[ROM_LAT-1]};
            end
        end

        // Credits reserve a FIFO slot for every in-flight read, so this can only fire on a logic bug.
        assert property (@(posedge clk) disable iff (!rst) !(fifoWr && (count_q == CNT_W'(DEPTH))));

        assign head                               = fifoMem_q[rdPtr_q];
        assign mem_en_flat[k]                     = issue;
        assign mem_addr_flat[k*ADDR_W +: ADDR_W]  = pc_q;
        assign inst_valid[k]                      = !empty;
        assign inst_flat[k*DATA_W +: DATA_W]      = empty ? '0 : head[ADDR_W +: DATA_W];
        assign inst_pc_flat[k*ADDR_W +: ADDR_W]   = empty ? '0 : head[ADDR_W-1:0];

`ifdef FETCH_PERF_EN
        logic [31:0] fetchCnt_q, flushCnt_q;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                fetchCnt_q <= '0;
                flushCnt_q <= '0;
            end else begin
                if (fifoPop && (fetchCnt_q != 32'hFFFF_FFFF)) begin
                    fetchCnt_q <= fetchCnt_q + 32'd1;
                end
                if (jump && (flushCnt_q != 32'hFFFF_FFFF)) begin
                    flushCnt_q <= flushCnt_q + 32'd1;
                end
            end
        end

        assign perf_fetch_flat[k*32 +: 32] = fetchCnt_q;
        assign perf_flush_flat[k*32 +: 32] = flushCnt_q;
`endif
    end

endmodule

// File: tb/tb_multi_fetch_unit.sv
// Scoreboard bench for multi_fetch_unit: each channel's expected instruction stream is queued and checked on every handshake.
module tb_multi_fetch_unit;

    localparam int                NUM_CH   = 5;
    localparam int                ADDR_W   = 16;
    localparam int                DATA_W   = 32;
    localparam int                ROM_LAT  = 2;
    localparam int                DEPTH    = 4;
    localparam logic [ADDR_W-1:0] RESET_PC = 16'h0000;
    localparam int                QFILL    = 8;
    localparam logic [NUM_CH-1:0] ALL      = '1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH-1:0]        mem_en_flat;
    logic [NUM_CH*ADDR_W-1:0] mem_addr_flat;
    logic [NUM_CH*DATA_W-1:0] mem_rdata_flat;
    logic [NUM_CH-1:0]        inst_valid;
    logic [NUM_CH-1:0]        inst_ready;
    logic [NUM_CH*DATA_W-1:0] inst_flat;
    logic [NUM_CH*ADDR_W-1:0] inst_pc_flat;
    logic [NUM_CH-1:0]        jump_detected;
    logic [NUM_CH*ADDR_W-1:0] jump_addr_flat;
`ifdef FETCH_PERF_EN
    logic [NUM_CH*32-1:0]     perf_fetch_flat;
    logic [NUM_CH*32-1:0]     perf_flush_flat;
`endif

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] expQ [NUM_CH][$];
    logic [ADDR_W-1:0] streamNext [NUM_CH];
    logic [ADDR_W-1:0] monPc;
    int unsigned       popCount [NUM_CH];
    int unsigned       jumpCount [NUM_CH];
    int                stallCnt [NUM_CH];
    bit                romValidHist [NUM_CH][ROM_LAT+1];
    bit [ADDR_W-1:0]   romAddrHist [NUM_CH][ROM_LAT+1];

    always #5 clk = ~clk;

    multi_fetch_unit #(
        .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .ROM_LAT(ROM_LAT), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem_en_flat(mem_en_flat),
        .mem_addr_flat(mem_addr_flat),
        .mem_rdata_flat(mem_rdata_flat),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_flat(inst_flat),
        .inst_pc_flat(inst_pc_flat),
        .jump_detected(jump_detected),
        .jump_addr_flat(jump_addr_flat)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_flat(perf_fetch_flat),
        .perf_flush_flat(perf_flush_flat)
`endif
    );

    function automatic logic [DATA_W-1:0] romData(input int k, input logic [ADDR_W-1:0] a);
        return {a, ~a} ^ (32'h9E37_79B9 * 32'(k + 1));
    endfunction

    // ROM: returns romData(addr) exactly ROM_LAT cycles after the enable, random garbage otherwise.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            for (int i = ROM_LAT; i > 0; i--) begin
                romValidHist[k][i] = romValidHist[k][i-1];
                romAddrHist[k][i]  = romAddrHist[k][i-1];
            end
            romValidHist[k][0] = (mem_en_flat[k] === 1'b1);
            romAddrHist[k][0]  = mem_addr_flat[k*ADDR_W +: ADDR_W];
            mem_rdata_flat[k*DATA_W +: DATA_W] = romValidHist[k][ROM_LAT] ?
                romData(k, romAddrHist[k][ROM_LAT]) : $urandom;
        end
    end

    // Monitor: every accepted word must be the next one of its channel's current stream.
    always @(negedge clk) begin
        for (int k = 0; k < NUM_CH; k++) begin
            if (rst !== 1'b1) begin
                stallCnt[k] = 0;
            end else begin
                if (inst_valid[k] && inst_ready[k]) begin
                    popCount[k]++;
                    if (expQ[k].size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL sb_empty ch%0d: got pc %h, required no word", k,
                                 inst_pc_flat[k*ADDR_W +: ADDR_W]);
                    end else begin
                        monPc = expQ[k].pop_front();
                        checks++;
                        if (inst_pc_flat[k*ADDR_W +: ADDR_W] !== monPc) begin
                            errors++;
                            $display("[TB] FAIL sb_pc ch%0d: got %h, required %h", k,
                                     inst_pc_flat[k*ADDR_W +: ADDR_W], monPc);
                        end
                        checks++;
                        if (inst_flat[k*DATA_W +: DATA_W] !== romData(k, monPc)) begin
                            errors++;
                            $display("[TB] FAIL sb_data ch%0d: got %h, required %h", k,
                                     inst_flat[k*DATA_W +: DATA_W], romData(k, monPc));
                        end
                    end
                end
                if (jump_detected[k] || inst_valid[k] || !inst_ready[k]) begin
                    stallCnt[k] = 0;
                end else begin
                    stallCnt[k]++;
                    if (stallCnt[k] > ROM_LAT + 1) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL liveness ch%0d: got %0d idle ready cycles, required at most %0d",
                                 k, stallCnt[k], ROM_LAT + 1);
                        stallCnt[k] = 0;
                    end
                end
            end
        end
    end

    task automatic refill();
        for (int k = 0; k < NUM_CH; k++) begin
            while (expQ[k].size() < QFILL) begin
                expQ[k].push_back(streamNext[k]);
                streamNext[k] = streamNext[k] + ADDR_W'(1);
            end
        end
    endtask

    // Advance one cycle; a jump issued last cycle restarts that channel's expected stream at its target.
    task automatic applyStimulus(input logic [NUM_CH-1:0] readyV, input logic [NUM_CH-1:0] jumpV,
                                 input logic [NUM_CH*ADDR_W-1:0] addrV);
        @(posedge clk);
        #1;
        for (int k = 0; k < NUM_CH; k++) begin
            if (jump_detected[k]) begin
                expQ[k].delete();
                streamNext[k] = jump_addr_flat[k*ADDR_W +: ADDR_W];
                jumpCount[k]++;
            end
        end
        inst_ready     = readyV;
        jump_detected  = jumpV;
        jump_addr_flat = addrV;
        refill();
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic clearModel();
        jump_detected = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            expQ[k].delete();
            streamNext[k] = RESET_PC;
            popCount[k]   = 0;
            jumpCount[k]  = 0;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_mem_en"}, 64'(mem_en_flat), 64'd0);
        checkOutput({tag, "_valid"}, 64'(inst_valid), 64'd0);
        checkOutput({tag, "_inst"}, 64'(|inst_flat), 64'd0);
        checkOutput({tag, "_pc"}, 64'(|inst_pc_flat), 64'd0);
    endtask

    logic [NUM_CH*ADDR_W-1:0] addr;
    logic [NUM_CH-1:0]        readyV, jumpV;
    logic [ADDR_W-1:0]        expPc;
    int                       ch2Issues;

    initial begin
        rst            = 1'b0;
        inst_ready     = ALL;
        jump_addr_flat = '0;
        clearModel();
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");

        // Release with channel 2 stalled: fill latency on all, credit stop and resume on channel 2.
        @(posedge clk);
        #1;
        rst        = 1'b1;
        inst_ready = ALL & ~(NUM_CH'(1) << 2);
        refill();
        ch2Issues = 0;
        for (int c = 0; c < 14; c++) begin
            if (c > 0) begin
                applyStimulus((c >= 10) ? ALL : (ALL & ~(NUM_CH'(1) << 2)), '0, '0);
            end
            @(negedge clk);
            if (c == 0) checkOutput("first_issue", 64'(mem_en_flat), 64'(ALL));
            if (c <= ROM_LAT + 1) begin
                checkOutput($sformatf("fill_valid_c%0d", c), 64'(inst_valid),
                            (c == ROM_LAT + 1) ? 64'(ALL) : 64'd0);
            end
            if (c < 10) ch2Issues += int'(mem_en_flat[2]);
            if (c == 5 || c == 9) begin
                checkOutput($sformatf("bp_hold_valid_c%0d", c), 64'(inst_valid[2]), 64'd1);
                checkOutput($sformatf("bp_hold_pc_c%0d", c), 64'(inst_pc_flat[2*ADDR_W +: ADDR_W]), 64'd0);
            end
            if (c == 10) begin
                checkOutput("bp_issue_count", 64'(ch2Issues), 64'(DEPTH));
                checkOutput("bp_stopped", 64'(mem_en_flat[2]), 64'd0);
            end
            if (c == 11) checkOutput("bp_resume", 64'(mem_en_flat[2]), 64'd1);
        end

        // Redirect channel 1 while its FIFO is full of words that must never appear.
        for (int c = 0; c < 5; c++) applyStimulus(ALL & ~NUM_CH'(2), '0, '0);
        addr = '0;
        addr[1*ADDR_W +: ADDR_W] = 16'h0040;
        applyStimulus(ALL & ~NUM_CH'(2), NUM_CH'(2), addr);
        @(negedge clk);
        checkOutput("jump_no_issue", 64'(mem_en_flat[1]), 64'd0);
        for (int c = 1; c <= ROM_LAT + 2; c++) begin
            applyStimulus(ALL & ~NUM_CH'(2), '0, '0);
            @(negedge clk);
            if (c == 1) begin
                checkOutput("jump_first_fetch", 64'({mem_en_flat[1], mem_addr_flat[1*ADDR_W +: ADDR_W]}),
                            64'({1'b1, 16'h0040}));
            end
            checkOutput($sformatf("jump_valid_c%0d", c), 64'(inst_valid[1]), (c == ROM_LAT + 2) ? 64'd1 : 64'd0);
            if (c == ROM_LAT + 2) checkOutput("jump_pc", 64'(inst_pc_flat[1*ADDR_W +: ADDR_W]), 64'h0040);
        end

        // Channel 3 wraps from 0xFFFE; channel 0 redirects in the same cycle as a pop.
        addr = '0;
        addr[3*ADDR_W +: ADDR_W] = 16'hFFFE;
        addr[0 +: ADDR_W]        = 16'h1234;
        applyStimulus(ALL, NUM_CH'(5'b01001), addr);
        @(negedge clk);
        checkOutput("pop_at_jump_valid", 64'(inst_valid[0]), 64'd1);
        for (int c = 1; c <= ROM_LAT + 4; c++) begin
            applyStimulus(ALL, '0, '0);
            @(negedge clk);
            if (c >= ROM_LAT + 2) begin
                expPc = 16'hFFFE + ADDR_W'(c - ROM_LAT - 2);
                checkOutput($sformatf("wrap_pc_c%0d", c), 64'(inst_pc_flat[3*ADDR_W +: ADDR_W]), 64'(expPc));
            end
        end

        // Back-to-back redirects on channel 4: only the second target survives.
        addr = '0;
        addr[4*ADDR_W +: ADDR_W] = 16'h0100;
        applyStimulus(ALL, NUM_CH'(1) << 4, addr);
        addr[4*ADDR_W +: ADDR_W] = 16'h0200;
        applyStimulus(ALL, NUM_CH'(1) << 4, addr);
        for (int c = 1; c <= ROM_LAT + 2; c++) begin
            applyStimulus(ALL, '0, '0);
            @(negedge clk);
            checkOutput($sformatf("b2b_valid_c%0d", c), 64'(inst_valid[4]), (c == ROM_LAT + 2) ? 64'd1 : 64'd0);
            if (c == ROM_LAT + 2) checkOutput("b2b_pc", 64'(inst_pc_flat[4*ADDR_W +: ADDR_W]), 64'h0200);
        end

        for (int n = 0; n < 300; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                readyV[k] = ($urandom_range(0, 3) != 0);
                jumpV[k]  = ($urandom_range(0, 39) == 0);
                addr[k*ADDR_W +: ADDR_W] = ($urandom_range(0, 1) == 1) ? ADDR_W'($urandom)
                                                                         : (16'hFFF0 + ADDR_W'($urandom_range(0, 15)));
            end
            applyStimulus(readyV, jumpV, addr);
        end

        // Mid-stream reset with reads in flight.
        for (int c = 0; c < 6; c++) applyStimulus(ALL, '0, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearModel();
        #1;
        checkResetOutputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        refill();
        @(negedge clk);
        checkOutput("restart_issue", 64'({mem_en_flat[0], mem_addr_flat[0 +: ADDR_W]}), 64'({1'b1, RESET_PC}));
        for (int c = 1; c <= ROM_LAT + 1; c++) begin
            applyStimulus(ALL, '0, '0);
            @(negedge clk);
            checkOutput($sformatf("restart_valid_c%0d", c), 64'(inst_valid), (c == ROM_LAT + 1) ? 64'(ALL) : 64'd0);
        end
        checkOutput("restart_pc", 64'(inst_pc_flat[0 +: ADDR_W]), 64'(RESET_PC));

        for (int n = 0; n < 100; n++) begin
            for (int k = 0; k < NUM_CH; k++) begin
                readyV[k] = ($urandom_range(0, 3) != 0);
                jumpV[k]  = ($urandom_range(0, 24) == 0);
                addr[k*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
            end
            applyStimulus(readyV, jumpV, addr);
        end
        applyStimulus('0, '0, '0);
        applyStimulus('0, '0, '0);
        @(negedge clk);

`ifdef FETCH_PERF_EN
        for (int k = 0; k < NUM_CH; k++) begin
            checkOutput($sformatf("perf_fetch_ch%0d", k), 64'(perf_fetch_flat[k*32 +: 32]), 64'(popCount[k]));
            checkOutput($sformatf("perf_flush_ch%0d", k), 64'(perf_flush_flat[k*32 +: 32]), 64'(jumpCount[k]));
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
